id_ex_stage: RTL

- ID/EX pipeline register for the 5-stage RISC-V core, directly upstream of the forwarding unit; drives its E-stage rs1/rs2 addresses.
- Contains load-use hazard detection, bubble insertion, branch-flush handling and external-stall hold.
- Provides saturating bubble/flush event counters for performance debug.

---
 rtl/id_ex_stage.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush and stall
// handling, plus saturating bubble/flush event counters.
//
// Ports:
//   i_clk, i_rst_n       clock, synchronous active-low reset
//   i_*D                 decoded D-stage instruction fields
//   i_flushE             kill the instruction entering E (redirect in EX)
//   i_stall_ext          freeze the whole front end (downstream stall)
//   o_stall_fd           hold PC and IF/ID (combinational)
//   o_*E                 registered E-stage copies of the D fields
//   o_bubble_cnt         load-use bubbles inserted (saturating)
//   o_flush_cnt          flush bubbles inserted (saturating)
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_validD,
    input  logic [XLEN-1:0]   i_pcD,
    input  logic [XLEN-1:0]   i_rs1_dataD,
    input  logic [XLEN-1:0]   i_rs2_dataD,
    input  logic [XLEN-1:0]   i_immD,
    input  logic [4:0]        i_rs1_addrD,
    input  logic [4:0]        i_rs2_addrD,
    input  logic              i_rs1_usedD,
    input  logic              i_rs2_usedD,
    input  logic [4:0]        i_rd_addrD,
    input  logic              i_rd_wrenD,
    input  logic              i_mem_rdenD,
    input  logic              i_mem_wrenD,
    input  logic              i_branchD,
    input  logic              i_jumpD,
    input  logic [CTRL_W-1:0] i_ctrlD,
    input  logic              i_flushE,
    input  logic              i_stall_ext,
    output logic              o_stall_fd,
    output logic              o_validE,
    output logic [XLEN-1:0]   o_pcE,
    output logic [XLEN-1:0]   o_rs1_dataE,
    output logic [XLEN-1:0]   o_rs2_dataE,
    output logic [XLEN-1:0]   o_immE,
    output logic [4:0]        o_rs1_addrE,
    output logic [4:0]        o_rs2_addrE,
    output logic [4:0]        o_rd_addrE,
    output logic              o_rd_wrenE,
    output logic              o_mem_rdenE,
    output logic              o_mem_wrenE,
    output logic              o_branchE,
    output logic              o_jumpE,
    output logic [CTRL_W-1:0] o_ctrlE,
    output logic [CNT_W-1:0]  o_bubble_cnt,
    output logic [CNT_W-1:0]  o_flush_cnt
);

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [4:0]        rs1_addr;
        logic [4:0]        rs2_addr;
        logic [4:0]        rd_addr;
        logic              rd_wren;
        logic              mem_rden;
        logic              mem_wren;
        logic              branch;
        logic              jump;
        logic [CTRL_W-1:0] ctrl;
    } id_ex_t;

    id_ex_t            e_q;
    id_ex_t            e_d;
    id_ex_t            d_in;
    logic [CNT_W-1:0]  bubble_cnt_q;
    logic [CNT_W-1:0]  bubble_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_d;

    logic rs1_hit;
    logic rs2_hit;
    logic hazard;
    logic do_hold;
    logic do_flush;
    logic do_bubble;
    logic do_load;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

    // Only a real load with a nonzero destination can create a hazard;
    // x0 is never written so readers of x0 never wait.
    assign rs1_hit = i_rs1_usedD && (i_rs1_addrD == e_q.rd_addr);
    assign rs2_hit = i_rs2_usedD && (i_rs2_addrD == e_q.rd_addr);

    assign hazard = e_q.valid && e_q.mem_rden
                 && (e_q.rd_addr != 5'd0) && i_validD
                 && (rs1_hit || rs2_hit);

    // A flush kills the dependent instruction anyway, so no need to hold D.
    assign o_stall_fd = i_stall_ext || (hazard && !i_flushE);

    // Mutually exclusive actions in priority order.
    assign do_hold   = i_stall_ext;
    assign do_flush  = !i_stall_ext && i_flushE;
    assign do_bubble = !i_stall_ext && !i_flushE && hazard;
    assign do_load   = !i_stall_ext && !i_flushE && !hazard;

    // An invalid D slot still carries its fields through, but every
    // side-effecting control bit is gated off.
    always_comb begin
        d_in          = '0;
        d_in.valid    = i_validD;
        d_in.pc       = i_pcD;
        d_in.rs1_data = i_rs1_dataD;
        d_in.rs2_data = i_rs2_dataD;
        d_in.imm      = i_immD;
        d_in.rs1_addr = i_rs1_addrD;
        d_in.rs2_addr = i_rs2_addrD;
        d_in.rd_addr  = i_rd_addrD;
        d_in.rd_wren  = i_validD && i_rd_wrenD;
        d_in.mem_rden = i_validD && i_mem_rdenD;
        d_in.mem_wren = i_validD && i_mem_wrenD;
        d_in.branch   = i_validD && i_branchD;
        d_in.jump     = i_validD && i_jumpD;
        d_in.ctrl     = i_ctrlD;
    end

    always_comb begin
        e_d          = e_q;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        unique case (1'b1)
            do_hold: begin
                e_d = e_q;
            end
            do_flush: begin
                e_d         = '0;
                flush_cnt_d = sat_inc(flush_cnt_q);
            end
            do_bubble: begin
                e_d          = '0;
                bubble_cnt_d = sat_inc(bubble_cnt_q);
            end
            do_load: begin
                e_d = d_in;
            end
            default: begin
                e_d = e_q;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            e_q          <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            e_q          <= e_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign o_validE     = e_q.valid;
    assign o_pcE        = e_q.pc;
    assign o_rs1_dataE  = e_q.rs1_data;
    assign o_rs2_dataE  = e_q.rs2_data;
    assign o_immE       = e_q.imm;
    assign o_rs1_addrE  = e_q.rs1_addr;
    assign o_rs2_addrE  = e_q.rs2_addr;
    assign o_rd_addrE   = e_q.rd_addr;
    assign o_rd_wrenE   = e_q.rd_wren;
    assign o_mem_rdenE  = e_q.mem_rden;
    assign o_mem_wrenE  = e_q.mem_wren;
    assign o_branchE    = e_q.branch;
    assign o_jumpE      = e_q.jump;
    assign o_ctrlE      = e_q.ctrl;
    assign o_bubble_cnt = bubble_cnt_q;
    assign o_flush_cnt  = flush_cnt_q;

endmodule
